// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-256 CTR datapath: block/word widths, types and byte reversal.
package aes_ctr_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_axis_block_packer.sv
// Packs 32-bit AXI-Stream words into 128-bit AES blocks with one output holding register.
// Optional build macro: AES_PACK_BYTESWAP_EN (byte-reverse every input word before storing it).
module aes_axis_block_packer
    import aes_ctr_pkg::*;
#(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [2:0]       m_axis_words,
    output logic [31:0]      blocks_out
);

    localparam int unsigned WORDS = OUT_W / IN_W;
    localparam int unsigned CNT_W = 3;

    if (IN_W != WORD_W || OUT_W != BLOCK_W || WORDS != WORDS_PER_BLOCK) begin : g_bad_width
        $error("aes_axis_block_packer supports only IN_W=32 and OUT_W=128");
    end

    block_t           r_acc;
    logic [1:0]       r_idx;
    logic             r_acc_last;
    logic             r_acc_done;
    logic             r_s_ready;
    block_t           r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic [CNT_W-1:0] r_m_words;
    logic [31:0]      r_blocks;

    word_t            w_word;
    block_t           w_blk;
    logic             w_accept;
    logic             w_drain;
    logic             w_complete;
    logic             w_acc_done_nxt;
    logic [CNT_W-1:0] w_words;

`ifdef AES_PACK_BYTESWAP_EN
    assign w_word = bswap32(word_t'(s_axis_tdata));
`else
    assign w_word = word_t'(s_axis_tdata);
`endif

    assign w_accept   = s_axis_tvalid & r_s_ready;
    assign w_drain    = r_m_valid & m_axis_tready;
    assign w_complete = w_accept & ((r_idx == 2'(WORDS - 1)) | s_axis_tlast);
    assign w_words    = CNT_W'(r_idx) + CNT_W'(1);

    // A waiting block clears only by a drain; a new one waits only if the output cannot take it.
    assign w_acc_done_nxt = r_acc_done ? !w_drain : (w_complete & r_m_valid & !w_drain);

    // Accumulator with the incoming word placed in slot idx; word 0 occupies the top bits.
    always_comb begin
        w_blk = r_acc;
        case (r_idx)
            2'd0:    w_blk[127:96] = w_word;
            2'd1:    w_blk[95:64]  = w_word;
            2'd2:    w_blk[63:32]  = w_word;
            default: w_blk[31:0]   = w_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_idx      <= '0;
            r_acc_last <= 1'b0;
            r_acc_done <= 1'b0;
            r_s_ready  <= 1'b0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_words  <= '0;
            r_blocks   <= '0;
        end else begin
            r_s_ready <= !w_acc_done_nxt;
            if (w_drain) begin
                r_blocks  <= r_blocks + 32'd1;
                r_m_valid <= 1'b0;
            end
            if (r_acc_done) begin
                if (w_drain) begin
                    r_m_data   <= r_acc;
                    r_m_valid  <= 1'b1;
                    r_m_last   <= r_acc_last;
                    r_m_words  <= w_words;
                    r_acc      <= '0;
                    r_idx      <= '0;
                    r_acc_last <= 1'b0;
                    r_acc_done <= 1'b0;
                end
            end else if (w_complete) begin
                if (!r_m_valid || w_drain) begin
                    r_m_data   <= w_blk;
                    r_m_valid  <= 1'b1;
                    r_m_last   <= s_axis_tlast;
                    r_m_words  <= w_words;
                    r_acc      <= '0;
                    r_idx      <= '0;
                    r_acc_last <= 1'b0;
                end else begin
                    // idx is kept so the word count is still known when the block drains
                    r_acc      <= w_blk;
                    r_acc_last <= s_axis_tlast;
                    r_acc_done <= 1'b1;
                end
            end else if (w_accept) begin
                r_acc <= w_blk;
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_words  = r_m_words;
    assign blocks_out    = r_blocks;

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Self-checking bench for aes_axis_block_packer: vector table, hand sequences and random traffic vs a queue model.
module tb_aes_axis_block_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [2:0]   m_words;
    logic [31:0]  blocks_out;

    int checks = 0;
    int errors = 0;

    aes_axis_block_packer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .m_axis_words  (m_words),
        .blocks_out    (blocks_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Value the packer stores for a raw input word (also used to pre-swap NIST words for driving).
    function automatic logic [31:0] pw(input logic [31:0] w);
`ifdef AES_PACK_BYTESWAP_EN
        return {<<8{w}};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: blocks completed but not yet transferred, in order.
    logic [127:0] q_data[$];
    logic [2:0]   q_words[$];
    logic         q_last[$];
    logic [127:0] part;
    int           part_n;
    logic [31:0]  model_blocks;
    bit           post_rst;
    bit           hold;
    logic [127:0] prev_data;
    logic         prev_last;
    logic [2:0]   prev_words;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
            check("rst_m_tdata", m_tdata, 128'(0));
            check("rst_m_tlast", 128'(m_tlast), 128'(0));
            check("rst_m_words", 128'(m_words), 128'(0));
            check("rst_blocks_out", 128'(blocks_out), 128'(0));
            check("rst_s_tready", 128'(s_tready), 128'(0));
            q_data.delete();
            q_words.delete();
            q_last.delete();
            part = '0;
            part_n = 0;
            model_blocks = '0;
            post_rst = 1'b1;
            hold = 1'b0;
        end else begin
            check("blocks_out", 128'(blocks_out), 128'(model_blocks));
            check("m_tvalid", 128'(m_tvalid), 128'(q_data.size() != 0));
            check("s_tready", 128'(s_tready), 128'(!post_rst && q_data.size() < 2));
            if (hold) begin
                check("stall_data", m_tdata, prev_data);
                check("stall_last", 128'(m_tlast), 128'(prev_last));
                check("stall_words", 128'(m_words), 128'(prev_words));
            end
            if (m_tvalid && q_data.size() > 0) begin
                check("blk_data", m_tdata, q_data[0]);
                check("blk_words", 128'(m_words), 128'(q_words[0]));
                check("blk_last", 128'(m_tlast), 128'(q_last[0]));
            end
            hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            prev_words = m_words;
            if (m_tvalid && m_tready && q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_words.pop_front());
                void'(q_last.pop_front());
                model_blocks = model_blocks + 32'd1;
            end
            if (s_tvalid && s_tready) begin
                part[127 - 32*part_n -: 32] = pw(s_tdata);
                part_n++;
                if (s_tlast || part_n == 4) begin
                    q_data.push_back(part);
                    q_words.push_back(3'(part_n));
                    q_last.push_back(s_tlast);
                    part = '0;
                    part_n = 0;
                end
            end
            post_rst = 1'b0;
        end
    end

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         mv;
        logic [127:0] md;
        logic         ml;
        logic [2:0]   mw;
        logic [31:0]  cnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int k;
        bit acc, pend, done;
        logic [127:0] d0;
        logic         l0;
        logic [2:0]   w0;

        rst = 1'b1;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Full block then short final block, m_tready held high.
        vt[0] = '{1, 32'h6BC1BEE2, 0, 0, '0, 0, 0, 0};
        vt[1] = '{1, 32'h2E409F96, 0, 0, '0, 0, 0, 0};
        vt[2] = '{1, 32'hE93D7E11, 0, 0, '0, 0, 0, 0};
        vt[3] = '{1, 32'h7393172A, 1, 0, '0, 0, 0, 0};
        vt[4] = '{1, 32'hAE2D8A57, 0, 1, 128'h6BC1BEE2_2E409F96_E93D7E11_7393172A, 1, 4, 0};
        vt[5] = '{1, 32'h1E03AC9C, 1, 0, '0, 0, 0, 1};
        vt[6] = '{0, 32'h0, 0, 1, 128'hAE2D8A57_1E03AC9C_00000000_00000000, 1, 2, 1};
        vt[7] = '{0, 32'h0, 0, 0, '0, 0, 0, 2};
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_tvalid = vt[i].v;
            s_tdata = pw(vt[i].d);
            s_tlast = vt[i].l;
            @(negedge clk);
            check($sformatf("vec%0d_mvalid", i), 128'(m_tvalid), 128'(vt[i].mv));
            check($sformatf("vec%0d_sready", i), 128'(s_tready), 128'(1));
            check($sformatf("vec%0d_count", i), 128'(blocks_out), 128'(vt[i].cnt));
            if (vt[i].mv) begin
                check($sformatf("vec%0d_data", i), m_tdata, vt[i].md);
                check($sformatf("vec%0d_last", i), 128'(m_tlast), 128'(vt[i].ml));
                check($sformatf("vec%0d_words", i), 128'(m_words), 128'(vt[i].mw));
            end
            tick();
        end

        // Byte order of slot 0 for raw E2BEC16B.
        s_tvalid = 1'b1;
        s_tdata = 32'hE2BEC16B;
        s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        @(negedge clk);
`ifdef AES_PACK_BYTESWAP_EN
        check("bswap_slot0", 128'(m_tdata[127:96]), 128'(32'h6BC1BEE2));
`else
        check("bswap_slot0", 128'(m_tdata[127:96]), 128'(32'hE2BEC16B));
`endif
        check("bswap_rest_zero", 128'(m_tdata[95:0]), 128'(0));
        check("bswap_words", 128'(m_words), 128'(1));
        tick();

        // Backpressure: 12 words offered, only 8 fit while the consumer stalls.
        m_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            s_tvalid = (k < 12);
            s_tdata = 32'h1000_0000 + 32'(k);
            s_tlast = (k == 11);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            tick();
            if (acc) k++;
        end
        check("bp_accepts", 128'(k), 128'(8));
        check("bp_s_tready_low", 128'(s_tready), 128'(0));
        @(negedge clk);
        d0 = m_tdata;
        l0 = m_tlast;
        w0 = m_words;
        check("bp_first_block", d0, {pw(32'h1000_0000), pw(32'h1000_0001), pw(32'h1000_0002), pw(32'h1000_0003)});
        repeat (5) tick();
        @(negedge clk);
        check("stall5_data", m_tdata, d0);
        check("stall5_last", 128'(m_tlast), 128'(l0));
        check("stall5_words", 128'(m_words), 128'(w0));
        tick();
        m_tready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            s_tvalid = (k < 12);
            s_tdata = 32'h1000_0000 + 32'(k);
            s_tlast = (k == 11);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            tick();
            if (acc) k++;
            done = (k == 12) && (q_data.size() == 0) && !m_tvalid;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        check("bp_drain_done", 128'(done), 128'(1));
        check("bp_block_total", 128'(blocks_out), 128'(6));

        // Reset asserted asynchronously with a 3-word partial block held.
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata = 32'hBAD0_0000 + 32'(i);
            tick();
        end
        s_tvalid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", 128'(m_tvalid), 128'(0));
        check("async_rst_tdata", m_tdata, 128'(0));
        check("async_rst_tlast", 128'(m_tlast), 128'(0));
        check("async_rst_words", 128'(m_words), 128'(0));
        check("async_rst_count", 128'(blocks_out), 128'(0));
        check("async_rst_sready", 128'(s_tready), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata = 32'hA000_0001 + 32'(i);
            s_tlast = (i == 3);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        @(negedge clk);
        check("post_rst_block", m_tdata,
              {pw(32'hA000_0001), pw(32'hA000_0002), pw(32'hA000_0003), pw(32'hA000_0004)});
        check("post_rst_words", 128'(m_words), 128'(4));
        repeat (3) tick();
        check("post_rst_count", 128'(blocks_out), 128'(1));

        // Random traffic with an AXI-compliant source and a randomly stalling sink.
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata = $urandom;
                s_tlast = ($urandom_range(0, 5) == 0);
            end
            m_tready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            pend = s_tvalid && !s_tready;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            done = (q_data.size() == 0) && !m_tvalid;
        end
        check("rand_drain_done", 128'(done), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_axis_block_packer.md
# aes_axis_block_packer

Upstream feeder for `aes256_ctr_mode`. It accepts a 32-bit AXI-Stream of plaintext words and packs every four words into one 128-bit AES block for the core's `s_axis` port. A short final block is zero-padded, and its valid-word count is reported alongside it. One output holding register lets input keep flowing while the core applies backpressure.

## Interface
- `IN_W`, default 32: input word width. Fixed at 32; any other value is rejected by elaboration assertion.
- `OUT_W`, default 128: output block width. Fixed at 128; `WORDS = OUT_W/IN_W = 4`.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `s_axis_tdata` in 32: plaintext word.
- `s_axis_tvalid` in 1: input word valid.
- `s_axis_tlast` in 1: last word of a message.
- `s_axis_tready` out 1: packer can accept a word.
- `m_axis_tdata` out 128: packed block. Word 0 is in [127:96], word 3 in [31:0].
- `m_axis_tvalid` out 1: block valid.
- `m_axis_tlast` out 1: block ends the message.
- `m_axis_tready` in 1: consumer (AES core) accepts the block.
- `m_axis_words` out 3: number of valid words in the block, 1..4.
- `blocks_out` out 32: count of blocks transferred on `m`. Wraps from 0xFFFFFFFF to 0.

## Operation
- **Accumulator.** 128-bit `acc`, 2-bit index `idx`, `acc_last` flag, `acc_done` flag.
  - An accepted input word (`tvalid & tready`) is written into slot `idx`, and `idx` increments.
  - An accept with `idx==3`, or with `s_axis_tlast=1`, completes the block.
  - Slots not written in a completed block are zero.
- **Output register** (`m_axis_*`). On block completion:
  - If the output register is empty, or is being drained this cycle (`m_axis_tvalid & m_axis_tready`), the block, its `tlast` and its word count (`idx+1`) load directly into the output register. `acc` and `idx` clear.
  - Otherwise `acc_done` is set and the block waits in `acc`.
- **Input ready.** `s_axis_tready = !acc_done` (registered state, no combinational path from `m_axis_tready`).
- **Draining a waiting block.** While `acc_done` is set, an output drain moves `acc` into the output register in that same cycle. `acc_done` and `idx` then clear, and `s_axis_tready` returns high the next cycle.
- `m_axis_tlast` is 1 only for a block completed by `s_axis_tlast`. A 4th word carrying `tlast` gives `words=4` and `tlast=1`.
- **Block counter.** `blocks_out` increments on every `m` handshake.
- Output data and flags stay stable while `m_axis_tvalid & !m_axis_tready` (AXI rule).
- **Reset, including mid-message:**
  - Discards any partial block and any held output.
  - All outputs go to 0: `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_words`, `blocks_out`, and `s_axis_tready`.
  - `s_axis_tready` rises on the first clock edge after `rst` deasserts.

## Timing
- Latency: the completing input word accepted at edge N gives `m_axis_tvalid=1` after edge N, i.e. visible in the cycle after the accept.
- Throughput: with `m_axis_tready=1`, 1 word per cycle sustained and no input stall; one block every 4 cycles.
- Backpressure: `s_axis_tready` falls in the cycle after a block completes into a full, non-draining output register. At most 8 words are buffered: 4 in the output register and 4 in `acc`.
- Simultaneous drain and completion in the same cycle is a direct load. No bubble and no stall.

## Configuration
- `AES_PACK_BYTESWAP_EN`
  - Defined: each 32-bit input word is byte-reversed (`[7:0]` becomes `[31:24]`, etc.) before it is stored, so little-endian DMA words map to NIST byte order.
  - Undefined: words are stored unmodified.
  - Zero padding and `m_axis_words` are unaffected either way.

## Structure
- Shared package `aes_ctr_pkg`:
  - `BLOCK_W=128`, `WORD_W=32`, `WORDS_PER_BLOCK=4`.
  - typedef `block_t` (logic [127:0]) and `word_t` (logic [31:0]).
  - function `bswap32`.
- No sub-module. The accumulator and output register are small enough to stay flat in one module.

## Test plan
- **Full block, no backpressure.** Words 6BC1BEE2, 2E409F96, E93D7E11, 7393172A (last on the 4th), `m_axis_tready=1`.
  - Expect one block 6BC1BEE2_2E409F96_E93D7E11_7393172A, `words=4`, `tlast=1`, one cycle after the 4th accept.
  - Expect `blocks_out=1`.
- **Short final block.** AE2D8A57, 1E03AC9C with `tlast` on the 2nd.
  - Expect AE2D8A57_1E03AC9C_00000000_00000000, `words=2`, `tlast=1`.
- **Backpressure.** `m_axis_tready=0`, 12 words streamed continuously.
  - `s_axis_tready` drops after 8 accepts.
  - After `tready=1`, three blocks come out in order with data intact and no word lost or duplicated.
- **Stall stability.** Hold `m_axis_tready=0` for 5 cycles with a block presented.
  - `m_axis_tdata`, `tlast` and `words` must not change.
- **Byte swap.** With `AES_PACK_BYTESWAP_EN` defined, input E2BEC16B.
  - Expect slot 0 = 6BC1BEE2.
- **Reset mid-message.** Accept 3 words, assert `rst` asynchronously, then release.
  - All outputs read 0 during reset.
  - The next 4-word message produces exactly one block with no stale words.
